// File: rtl/hmmm_loader_pkg.sv
// Shared constants, state encoding and state-decode helpers for the hmmm program loader.
package hmmm_loader_pkg;

  localparam int unsigned HMMM_ADDR_W     = 8;
  localparam int unsigned HMMM_WORD_W     = 16;
  localparam int unsigned HMMM_BYTE_W     = 8;
  localparam int unsigned HMMM_STB_W      = 1;
  localparam int unsigned HMMM_PGRM_WORDS = 256;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RST0     = 4'd1,
    ST_COUNT    = 4'd2,
    ST_BYTE_HI  = 4'd3,
    ST_BYTE_LO  = 4'd4,
    ST_STB_ADDR = 4'd5,
    ST_STB_DATA = 4'd6,
    ST_CKSUM    = 4'd7,
    ST_RST1     = 4'd8,
    ST_DONE     = 4'd9,
    ST_ERR      = 4'd10
  } state_e;

  function automatic logic st_busy(state_e s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERR});
  endfunction

  function automatic logic st_accept(state_e s);
    return s inside {ST_COUNT, ST_BYTE_HI, ST_BYTE_LO, ST_CKSUM};
  endfunction

endpackage

// File: rtl/hmmm_loader_asm.sv
// Byte-to-word assembler for the loader; also keeps the running XOR of accepted bytes.
import hmmm_loader_pkg::*;

module hmmm_loader_asm (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [HMMM_BYTE_W-1:0]   data_i,
  input  logic                     hi_we_i,
  input  logic                     lo_we_i,
  input  logic                     xor_clr_i,
  input  logic                     xor_acc_i,
  output logic [2*HMMM_BYTE_W-1:0] word_o,
  output logic [HMMM_BYTE_W-1:0]   xsum_o
);

  logic [HMMM_BYTE_W-1:0] hi_q, lo_q, xsum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      xsum_q <= '0;
    end else begin
      if (hi_we_i) hi_q <= data_i;
      if (lo_we_i) lo_q <= data_i;
      if (xor_clr_i)      xsum_q <= '0;
      else if (xor_acc_i) xsum_q <= xsum_q ^ data_i;
    end
  end

  assign word_o = {hi_q, lo_q};
  assign xsum_o = xsum_q;

endmodule

// File: rtl/hmmm_loader.sv
// Program-load master for the hmmm core: count byte + big-endian words -> pgrm_addr/pgrm_data strobes.
// Optional trailing checksum byte enabled by HMMM_LOADER_CKSUM_EN.
import hmmm_loader_pkg::*;

module hmmm_loader #(
  parameter int unsigned ADDR_W = HMMM_ADDR_W,
  parameter int unsigned WORD_W = HMMM_WORD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [HMMM_BYTE_W-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   pgrm_addr,
  output logic                   pgrm_data,
  output logic [WORD_W-1:0]      ld_data,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d, words_q, words_d;
  logic                   s_ready_q, s_ready_d;
  logic                   pgrm_addr_q, pgrm_addr_d, pgrm_data_q, pgrm_data_d;
  logic                   cpu_rst_q, cpu_rst_d, busy_q, busy_d, done_q, done_d;
  logic [WORD_W-1:0]      ld_data_q, ld_data_d;
  logic                   hi_we, lo_we, xor_clr, xor_acc, fire;
  logic [2*HMMM_BYTE_W-1:0] word;
  logic [HMMM_BYTE_W-1:0] xsum;

  assign fire = s_valid && s_ready_q;

  hmmm_loader_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .data_i    (s_data),
    .hi_we_i   (hi_we),
    .lo_we_i   (lo_we),
    .xor_clr_i (xor_clr),
    .xor_acc_i (xor_acc),
    .word_o    (word),
    .xsum_o    (xsum)
  );

  // Next state plus next values of every registered output, decoded from state_d.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    words_d = words_q;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    xor_clr = 1'b0;
    xor_acc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_RST0;
      ST_RST0: begin
        xor_clr = 1'b1;
        state_d = ST_COUNT;
      end
      ST_COUNT: if (fire) begin
        count_d = (s_data == '0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(s_data);
        words_d = '0;
        xor_acc = 1'b1;
        state_d = ST_BYTE_HI;
      end
      ST_BYTE_HI: if (fire) begin
        hi_we   = 1'b1;
        xor_acc = 1'b1;
        state_d = ST_BYTE_LO;
      end
      ST_BYTE_LO: if (fire) begin
        lo_we   = 1'b1;
        xor_acc = 1'b1;
        state_d = ST_STB_ADDR;
      end
      ST_STB_ADDR: state_d = ST_STB_DATA;
      ST_STB_DATA: begin
        words_d = words_q + CNT_W'(1);
        if (words_d == count_q) begin
`ifdef HMMM_LOADER_CKSUM_EN
          state_d = ST_CKSUM;
`else
          state_d = ST_RST1;
`endif
        end else begin
          state_d = ST_BYTE_HI;
        end
      end
`ifdef HMMM_LOADER_CKSUM_EN
      ST_CKSUM: if (fire) state_d = (s_data == xsum) ? ST_RST1 : ST_ERR;
`endif
      ST_RST1: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    s_ready_d   = st_accept(state_d);
    busy_d      = st_busy(state_d);
    pgrm_addr_d = (state_d == ST_STB_ADDR);
    pgrm_data_d = (state_d == ST_STB_DATA);
    cpu_rst_d   = (state_d == ST_RST0) || (state_d == ST_RST1);
    done_d      = (state_d == ST_DONE);
    ld_data_d   = '0;
    if (state_d == ST_STB_ADDR)      ld_data_d = WORD_W'(words_q[ADDR_W-1:0]);
    else if (state_d == ST_STB_DATA) ld_data_d = WORD_W'(word);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      words_q     <= '0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      pgrm_addr_q <= 1'b0;
      pgrm_data_q <= 1'b0;
      cpu_rst_q   <= 1'b0;
      done_q      <= 1'b0;
      ld_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      words_q     <= words_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      pgrm_addr_q <= pgrm_addr_d;
      pgrm_data_q <= pgrm_data_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      ld_data_q   <= ld_data_d;
    end
  end

`ifdef HMMM_LOADER_CKSUM_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state_d == ST_ERR);
  end
  assign err = err_q;
`else
  // Running XOR has no consumer without the checksum byte.
  logic unused_xsum;
  assign unused_xsum = ^xsum;
  assign err = 1'b0;
`endif

  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign pgrm_addr = pgrm_addr_q;
  assign pgrm_data = pgrm_data_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_hmmm_loader.sv
// Self-checking bench for hmmm_loader: streams are checked against an event-list model of the load.
module tb_hmmm_loader;

  localparam int EV_RST  = 32'h1_0000;
  localparam int EV_ADDR = 32'h2_0000;
  localparam int EV_DATA = 32'h3_0000;

  logic        clk = 1'b0;
  logic        rst, start, s_valid;
  logic [7:0]  s_data;
  logic        s_ready, pgrm_addr, pgrm_data, cpu_rst, busy, done, err;
  logic [15:0] ld_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] stim_q[$];
  int         exp_q[$];
  int         obs_q[$];
  bit         exp_done, exp_err;

  hmmm_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .pgrm_addr (pgrm_addr),
    .pgrm_data (pgrm_data),
    .ld_data   (ld_data),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference: a load is cpu_rst, then (addr i, word i) for each word, then cpu_rst unless checksum fails.
  task automatic model_session();
    int n;
    logic [7:0] x;
    exp_q.delete();
    n = (stim_q[0] == 8'd0) ? 256 : int'(stim_q[0]);
    x = stim_q[0];
    exp_q.push_back(EV_RST);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(EV_ADDR | i);
      exp_q.push_back(EV_DATA | int'({stim_q[1+2*i], stim_q[2+2*i]}));
      x = x ^ stim_q[1+2*i] ^ stim_q[2+2*i];
    end
`ifdef HMMM_LOADER_CKSUM_EN
    exp_done = (stim_q[2*n+1] == x);
    exp_err  = !exp_done;
    if (exp_done) exp_q.push_back(EV_RST);
`else
    exp_done = 1'b1;
    exp_err  = 1'b0;
    exp_q.push_back(EV_RST);
`endif
  endtask

  task automatic make_stream(input logic [7:0] count);
    int n;
    logic [7:0] x;
    stim_q.delete();
    n = (count == 8'd0) ? 256 : int'(count);
    stim_q.push_back(count);
    x = count;
    for (int i = 0; i < 2 * n; i++) begin
      stim_q.push_back(8'($urandom));
      x = x ^ stim_q[stim_q.size()-1];
    end
`ifdef HMMM_LOADER_CKSUM_EN
    stim_q.push_back(x);
`endif
  endtask

  task automatic basic_stream();
    stim_q = '{8'h02, 8'h1F, 8'h64, 8'h01, 8'h01};
`ifdef HMMM_LOADER_CKSUM_EN
    stim_q.push_back(8'h79);
`endif
  endtask

  // Drives one load session from stim_q, records the strobe sequence and compares it with the model.
  task automatic run_session(input string name, input bit rand_valid, input bit poke_start);
    int  idx = 0;
    int  viol = 0;
    bit  ended = 0;
    bit  prev_addr = 0;
    bit  v;
    model_session();
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    s_valid = 1'b0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cpu_rst)   obs_q.push_back(EV_RST);
      if (pgrm_addr) obs_q.push_back(EV_ADDR | int'(ld_data));
      if (pgrm_data) obs_q.push_back(EV_DATA | int'(ld_data));
      if (pgrm_addr && pgrm_data) viol++;
      if (pgrm_data && !prev_addr) viol++;
      if (!busy && (ld_data != 16'h0 || s_ready)) viol++;
      prev_addr = pgrm_addr;
      if (cyc > 0 && !busy) begin
        ended = 1;
        break;
      end
      if (idx < stim_q.size()) begin
        v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        s_valid = v;
        s_data = v ? stim_q[idx] : 8'($urandom);
        if (v && s_ready) idx++;
        if (poke_start && $urandom_range(0, 3) == 0) start = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    start = 1'b0;

    checks++;
    if (!ended) begin
      errors++;
      $display("FAIL %s timeout: busy still %0b, required 0 within budget", name, busy);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s event_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (errors < 20)
          $display("FAIL %s event[%0d]: got %05h required %05h", name, i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({done, err} !== {exp_done, exp_err}) begin
      errors++;
      $display("FAIL %s done_err: got %0b%0b required %0b%0b", name, done, err, exp_done, exp_err);
    end
    checks++;
    if (idx !== stim_q.size()) begin
      errors++;
      $display("FAIL %s bytes_consumed: got %0d required %0d", name, idx, stim_q.size());
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL %s strobe_rules: got %0d violations required 0", name, viol);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({s_ready, pgrm_addr, pgrm_data, cpu_rst, busy, done, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %07b required 0000000",
               {s_ready, pgrm_addr, pgrm_data, cpu_rst, busy, done, err});
    end
    checks++;
    if (ld_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_ld_data: got %04h required 0000", ld_data);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %0b required 0", busy);
    end
  endtask

  task automatic test_basic();
    basic_stream();
    run_session("basic", 1'b0, 1'b0);
  endtask

  task automatic test_random_valid();
    for (int k = 0; k < 3; k++) begin
      basic_stream();
      run_session("random_valid", 1'b1, 1'b0);
    end
  endtask

  task automatic test_start_while_busy();
    basic_stream();
    run_session("start_busy", 1'b1, 1'b1);
  endtask

  task automatic test_full_program();
    make_stream(8'h00);
    run_session("full_256", 1'b0, 1'b0);
  endtask

  task automatic test_random_programs();
    for (int k = 0; k < 6; k++) begin
      make_stream(8'($urandom_range(1, 20)));
      run_session("random_prog", 1'b1, 1'b0);
    end
  endtask

`ifdef HMMM_LOADER_CKSUM_EN
  task automatic test_cksum_bad();
    stim_q = '{8'h02, 8'h1F, 8'h64, 8'h01, 8'h01, 8'h00};
    run_session("cksum_bad", 1'b0, 1'b0);
    basic_stream();
    run_session("cksum_good_after_err", 1'b0, 1'b0);
  endtask
`endif

  task automatic test_mid_reset();
    int idx = 0;
    basic_stream();
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 200 && idx < 4; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      s_valid = 1'b1;
      s_data = stim_q[idx];
      if (s_ready) idx++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    checks++;
    if (busy !== 1'b1 || idx !== 4) begin
      errors++;
      $display("FAIL mid_reset_setup: busy %0b bytes %0d, required busy 1 bytes 4", busy, idx);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({s_ready, pgrm_addr, pgrm_data, cpu_rst, busy, done, err, ld_data} !== 23'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %06h required 000000",
               {s_ready, pgrm_addr, pgrm_data, cpu_rst, busy, done, err, ld_data});
    end
    make_stream(8'h03);
    run_session("reload_after_rst", 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_valid();
    test_start_while_busy();
    test_full_program();
    test_random_programs();
`ifdef HMMM_LOADER_CKSUM_EN
    test_cksum_bad();
`endif
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
